// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package dmem_arb_pkg;
  localparam int WORDS_DEF    = 64;
  localparam int LOCK_MAX_DEF = 16;

  typedef enum logic {ARB, LOCKED} state_e;
  typedef enum logic {PORT_C, PORT_D} port_e;

  // Word-aligned and inside the memory.
  function automatic logic addr_legal(input logic [31:0] addr, input int words);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(words));
  endfunction
endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic  [1:0] valid_i,      // bit0 = CPU, bit1 = debug/DMA
  input  port_e       last_grant_i,
  output logic  [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    case (valid_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (last_grant_i == PORT_D) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/dmem_arbiter.sv
// CPU / debug arbiter onto a single-ported data memory, with port locking
// and an idle timeout that force-releases a stale lock.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WORDS    = WORDS_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_valid_i,
  output logic        c_ready_o,
  input  logic [31:0] c_addr_i,
  input  logic [31:0] c_wdata_i,
  input  logic        c_we_i,
  input  logic        c_lock_i,
  output logic        c_rvalid_o,
  output logic [31:0] c_rdata_o,
  output logic        c_err_o,
  input  logic        d_valid_i,
  output logic        d_ready_o,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic        d_we_i,
  input  logic        d_lock_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic        m_we_o,
  input  logic [31:0] m_rdata_i,
  output logic        lock_tmo_o
);
  localparam int CW = $clog2(LOCK_MAX + 1);

  state_e        state_q, state_d;
  port_e         owner_q, owner_d, last_q, last_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          tmo_q, tmo_d;
  logic [1:0]    rvalid_q, rvalid_d, err_q, err_d, rd_q, rd_d;

  logic [1:0]    rr_gnt, ready, acc;
  logic          any_acc, legal, sel_we, sel_lock;
  logic [31:0]   sel_addr, sel_wdata;

  dmem_rr_pick u_pick (
    .valid_i      ({d_valid_i, c_valid_i}),
    .last_grant_i (last_q),
    .gnt_o        (rr_gnt)
  );

  // Only the lock owner may be accepted while LOCKED; reset blocks all accepts.
  always_comb begin
    ready = 2'b00;
    if (!rst) begin
      if (state_q == ARB) ready = rr_gnt;
      else                ready = (owner_q == PORT_C) ? 2'b01 : 2'b10;
    end
  end

  assign acc       = ready & {d_valid_i, c_valid_i};
  assign any_acc   = |acc;
  assign sel_addr  = acc[0] ? c_addr_i  : d_addr_i;
  assign sel_wdata = acc[0] ? c_wdata_i : d_wdata_i;
  assign sel_we    = acc[0] ? c_we_i    : d_we_i;
  assign sel_lock  = acc[0] ? c_lock_i  : d_lock_i;
  assign legal     = any_acc && addr_legal(sel_addr, WORDS);

  assign c_ready_o = ready[0];
  assign d_ready_o = ready[1];
  assign m_addr_o  = legal ? sel_addr  : 32'h0;
  assign m_wdata_o = legal ? sel_wdata : 32'h0;
  assign m_we_o    = legal & sel_we;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    idle_d   = idle_q;
    tmo_d    = tmo_q;
    rvalid_d = acc;
    err_d    = acc & {2{~legal}};
    rd_d     = acc & {2{legal & ~sel_we}};
    if (any_acc) last_d = acc[0] ? PORT_C : PORT_D;
    if (state_q == ARB) begin
      if (any_acc && sel_lock) begin
        state_d = LOCKED;
        owner_d = acc[0] ? PORT_C : PORT_D;
        idle_d  = '0;
      end
    end else begin
      if (any_acc) begin
        idle_d = '0;
        if (!sel_lock) state_d = ARB;
      end else if (idle_q == CW'(LOCK_MAX - 1)) begin
        state_d = ARB;
        idle_d  = '0;
        tmo_d   = 1'b1;
      end else begin
        idle_d = idle_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB;
      owner_q  <= PORT_C;
      last_q   <= PORT_D;
      idle_q   <= '0;
      tmo_q    <= 1'b0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rd_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      idle_q   <= idle_d;
      tmo_q    <= tmo_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  // Responses in flight when reset arrives are suppressed immediately.
  assign c_rvalid_o = rvalid_q[0] & ~rst;
  assign d_rvalid_o = rvalid_q[1] & ~rst;
  assign c_err_o    = err_q[0] & ~rst;
  assign d_err_o    = err_q[1] & ~rst;
  assign c_rdata_o  = (rd_q[0] & ~rst) ? m_rdata_i : 32'h0;
  assign d_rdata_o  = (rd_q[1] & ~rst) ? m_rdata_i : 32'h0;
  assign lock_tmo_o = tmo_q & ~rst;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a response scoreboard per port.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c_valid, c_ready, c_we, c_lock, c_rvalid, c_err;
  logic d_valid, d_ready, d_we, d_lock, d_rvalid, d_err;
  logic [31:0] c_addr, c_wdata, c_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic m_we, lock_tmo;
  logic mem_init = 1'b1;
  logic [31:0] mem [64];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {logic v; logic [31:0] a; logic [31:0] w; logic we; logic lk;} req_t;
  typedef struct packed {logic [31:0] d; logic e;} rsp_t;
  typedef struct {logic [31:0] d; logic e; int cyc;} exp_t;
  exp_t cq[$];
  exp_t dq[$];

  localparam req_t NONE = '0;
  localparam rsp_t Z    = '0;
  localparam rsp_t ERR  = '{d: 32'h0, e: 1'b1};

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_valid_i(c_valid), .c_ready_o(c_ready), .c_addr_i(c_addr), .c_wdata_i(c_wdata),
    .c_we_i(c_we), .c_lock_i(c_lock), .c_rvalid_o(c_rvalid), .c_rdata_o(c_rdata), .c_err_o(c_err),
    .d_valid_i(d_valid), .d_ready_o(d_ready), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_we_i(d_we), .d_lock_i(d_lock), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
    .m_addr_o(m_addr), .m_wdata_o(m_wdata), .m_we_o(m_we), .m_rdata_i(m_rdata),
    .lock_tmo_o(lock_tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: word i initially holds 0xA0000000+i, read data one cycle later.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (m_we) begin
      mem[m_addr[7:2]] <= m_wdata;
    end
    m_rdata <= mem[m_addr[7:2]];
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic req_t rd(input logic [31:0] a, input logic lk = 1'b0);
    return '{v: 1'b1, a: a, w: 32'h0, we: 1'b0, lk: lk};
  endfunction

  function automatic req_t wr(input logic [31:0] a, input logic [31:0] w);
    return '{v: 1'b1, a: a, w: w, we: 1'b1, lk: 1'b0};
  endfunction

  function automatic rsp_t ok(input logic [31:0] d);
    return '{d: d, e: 1'b0};
  endfunction

  task automatic drive(input req_t c, input req_t d);
    c_valid = c.v; c_addr = c.a; c_wdata = c.w; c_we = c.we; c_lock = c.lk;
    d_valid = d.v; d_addr = d.a; d_wdata = d.w; d_we = d.we; d_lock = d.lk;
  endtask

  // One cycle: drive at negedge, check accepts/m_we, queue expected responses.
  task automatic step(input req_t c, input req_t d, input logic [1:0] eacc,
                      input rsp_t ec, input rsp_t ed, input logic emwe);
    drive(c, d);
    #1;
    chk1("c_accept", c_valid & c_ready, eacc[0]);
    chk1("d_accept", d_valid & d_ready, eacc[1]);
    chk1("m_we", m_we, emwe);
    if (c_valid && c_ready) cq.push_back('{d: ec.d, e: ec.e, cyc: cyc + 1});
    if (d_valid && d_ready) dq.push_back('{d: ed.d, e: ed.e, cyc: cyc + 1});
    @(negedge clk);
  endtask

  task automatic mon(input bit isd, input logic rv, input logic [31:0] rdat, input logic er);
    exp_t e;
    int n;
    string p;
    p = isd ? "d" : "c";
    n = isd ? dq.size() : cq.size();
    if (rv) begin
      if (n == 0) begin
        checks++; errors++;
        $display("FAIL %s_unexpected_rvalid: got rvalid=1 want 0 (cycle %0d)", p, cyc);
      end else begin
        if (isd) e = dq.pop_front(); else e = cq.pop_front();
        chk32({p, "_rdata"}, rdat, e.d);
        chk1({p, "_err"}, er, e.e);
        chk32({p, "_rvalid_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk32({p, "_rdata_idle"}, rdat, 32'h0);
      chk1({p, "_err_idle"}, er, 1'b0);
      if (n != 0) begin
        if (isd) e = dq[0]; else e = cq[0];
        if (e.cyc <= cyc) begin
          checks++; errors++;
          $display("FAIL %s_missing_rvalid: got rvalid=0 want 1 (cycle %0d)", p, cyc);
          if (isd) void'(dq.pop_front()); else void'(cq.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    #2;
    mon(1'b0, c_rvalid, c_rdata, c_err);
    mon(1'b1, d_rvalid, d_rdata, d_err);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset, with requests pending that must not be accepted.
    drive(wr(32'h10, 32'h1234_5678), rd(32'h0));
    @(negedge clk);
    mem_init = 1'b0;
    #1;
    chk1("rst_c_ready", c_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chk1("rst_m_we", m_we, 1'b0);
    chk1("rst_c_rvalid", c_rvalid, 1'b0);
    chk1("rst_lock_tmo", lock_tmo, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Tie after reset: CPU first, debug next.
    step(rd(32'h0), rd(32'h4), 2'b01, ok(32'hA000_0000), Z, 1'b0);
    step(NONE, rd(32'h4), 2'b10, Z, ok(32'hA000_0001), 1'b0);
    // Write then read back through the other port.
    step(wr(32'h8, 32'hDEAD_BEEF), NONE, 2'b01, Z, Z, 1'b1);
    step(NONE, rd(32'h8), 2'b10, Z, ok(32'hDEAD_BEEF), 1'b0);
    // Round-robin ties in both directions.
    step(rd(32'hC), rd(32'h10), 2'b01, ok(32'hA000_0003), Z, 1'b0);
    step(rd(32'h0), rd(32'h10), 2'b10, Z, ok(32'hA000_0004), 1'b0);
    step(rd(32'h0), NONE, 2'b01, ok(32'hA000_0000), Z, 1'b0);
    // Illegal addresses and the last legal word.
    step(NONE, rd(32'h2), 2'b10, Z, ERR, 1'b0);
    step(NONE, rd(32'h100), 2'b10, Z, ERR, 1'b0);
    step(NONE, wr(32'h100, 32'h55), 2'b10, Z, ERR, 1'b0);
    step(NONE, rd(32'hFC), 2'b10, Z, ok(32'hA000_003F), 1'b0);

    // Lock by CPU, renewed once; debug starved until unlock.
    step(rd(32'h0, 1'b1), rd(32'h4), 2'b01, ok(32'hA000_0000), Z, 1'b0);
    for (int i = 0; i < 3; i++) step(NONE, rd(32'h4), 2'b00, Z, Z, 1'b0);
    step(rd(32'h8, 1'b1), rd(32'h4), 2'b01, ok(32'hDEAD_BEEF), Z, 1'b0);
    for (int i = 0; i < 15; i++) step(NONE, rd(32'h4), 2'b00, Z, Z, 1'b0);
    chk1("lock_tmo_renewed", lock_tmo, 1'b0);
    step(rd(32'hC), rd(32'h4), 2'b01, ok(32'hA000_0003), Z, 1'b0);
    step(NONE, rd(32'h4), 2'b10, Z, ok(32'hA000_0001), 1'b0);

    // Lock then idle until the forced release.
    step(rd(32'h4, 1'b1), NONE, 2'b01, ok(32'hA000_0001), Z, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk1("lock_tmo_before", lock_tmo, 1'b0);
      step(NONE, rd(32'h10), 2'b00, Z, Z, 1'b0);
    end
    chk1("lock_tmo_set", lock_tmo, 1'b1);
    step(NONE, rd(32'h10), 2'b10, Z, ok(32'hA000_0004), 1'b0);
    step(rd(32'h0), rd(32'h4), 2'b01, ok(32'hA000_0000), Z, 1'b0);
    step(NONE, NONE, 2'b00, Z, Z, 1'b0);
    chk1("lock_tmo_sticky", lock_tmo, 1'b1);

    // Reset right after a CPU read accept drops its response.
    drive(rd(32'h0), NONE);
    #1;
    chk1("pre_rst_accept", c_valid & c_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(wr(32'h10, 32'h1234_5678), rd(32'h4));
    #1;
    chk1("rst2_c_rvalid", c_rvalid, 1'b0);
    chk32("rst2_c_rdata", c_rdata, 32'h0);
    chk1("rst2_c_ready", c_ready, 1'b0);
    chk1("rst2_d_ready", d_ready, 1'b0);
    chk1("rst2_m_we", m_we, 1'b0);
    chk32("rst2_m_addr", m_addr, 32'h0);
    chk1("rst2_lock_tmo", lock_tmo, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(NONE, NONE);
    #1;
    chk1("post_rst_c_rvalid", c_rvalid, 1'b0);
    chk1("post_rst_d_rvalid", d_rvalid, 1'b0);
    chk1("post_rst_lock_tmo", lock_tmo, 1'b0);
    @(negedge clk);
    // Write during reset must not have landed; CPU wins first tie again.
    step(rd(32'h10), rd(32'h4), 2'b01, ok(32'hA000_0004), Z, 1'b0);
    step(NONE, rd(32'h4), 2'b10, Z, ok(32'hA000_0001), 1'b0);
    step(NONE, NONE, 2'b00, Z, Z, 1'b0);
    step(NONE, NONE, 2'b00, Z, Z, 1'b0);

    chk32("c_queue_drained", 32'(cq.size()), 32'h0);
    chk32("d_queue_drained", 32'(dq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WORDS, default 64, memory depth in 32-bit words; legal word index 0..WORDS-1.
REQ-002 Parameter LOCK_MAX, default 16, maximum idle cycles the owner may hold a lock before forced release.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 c_valid/c_ready  input/output  1/1  CPU port request handshake.
REQ-006 c_addr  input  32  CPU byte address.
REQ-007 c_wdata  input  32  CPU write data.
REQ-008 c_we  input  1  CPU write (1) or read (0).
REQ-009 c_lock  input  1  CPU holds the port after this request.
REQ-010 c_rvalid, c_rdata, c_err  output  1, 32, 1  CPU response: strobe, read data, error.
REQ-011 d_* signals SHALL duplicate REQ-005..REQ-010 for the debug/DMA port.
REQ-012 m_addr, m_wdata, m_we  output  32, 32, 1  memory request; memory read data returns one cycle later.
REQ-013 m_rdata  input  32  memory read data, valid the cycle after a read is issued.
REQ-014 lock_tmo  output  1  sticky flag: a lock was force-released.

Function
REQ-015 At most one request SHALL be accepted per cycle; acceptance = x_valid & x_ready, and x_ready is combinational from state and valids.
REQ-016 In state ARB: one valid port -> that port is granted; both valid -> the port not granted most recently wins (last_grant reg).
REQ-017 An accepted request is legal iff addr[1:0]==0 and addr[31:2] < WORDS; only a legal request drives m_addr=addr, m_wdata=wdata, m_we=we in the same cycle.
REQ-018 With no legal accept, m_we SHALL be 0, m_addr 0, m_wdata 0.
REQ-019 Every accepted request SHALL produce exactly one x_rvalid pulse on its own port, exactly 1 cycle after acceptance; back-to-back accepts give back-to-back responses.
REQ-020 Response data: legal read -> m_rdata; write or illegal -> 0; x_err=1 only for illegal requests.
REQ-021 Accepting a request with lock=1 SHALL move the FSM ARB->LOCKED with owner = that port; in LOCKED, the non-owner x_ready=0.
REQ-022 In LOCKED, an owner accept with lock=0 SHALL return the FSM to ARB on the next cycle; an owner accept with lock=1 stays LOCKED and clears the idle counter.
REQ-023 In LOCKED, the idle counter increments each cycle without an owner accept; on reaching LOCK_MAX, the FSM goes to ARB and lock_tmo is set.
REQ-024 lock_tmo SHALL stay 1 until rst.
REQ-025 last_grant updates on every accept, including accepts in LOCKED.

Reset
REQ-026 rst SHALL force: FSM=ARB, last_grant=D (CPU wins the first tie), idle counter=0, lock_tmo=0, all rvalid/err=0, all rdata=0.
REQ-027 A response pending when rst is asserted SHALL be dropped; no rvalid pulses in the cycle after reset.
REQ-028 rst SHALL override a simultaneous accept; no memory write is issued in a reset cycle.

Structure
REQ-029 Package dmem_arb_pkg SHALL hold the FSM enum {ARB, LOCKED}, the port-id enum {PORT_C, PORT_D}, and the WORDS/LOCK_MAX defaults.
REQ-030 The 2-way round-robin pick SHALL be a sub-module dmem_rr_pick (inputs: valids and last_grant; output: grant one-hot).

Verification
REQ-031 Both valid with reads at 0x0 and 0x4 after reset -> C accepted cycle 0 and D cycle 1; c_rvalid at cycle 1, d_rvalid at cycle 2, data match.
REQ-032 C writes 0xDEADBEEF to 0x8, then D reads 0x8 -> d_rdata=0xDEADBEEF, c_rdata=0 on the write ack.
REQ-033 D reads 0x2 and 0x100 (WORDS=64) -> m_we=0, d_err=1 both times, d_rdata=0.
REQ-034 C accepts with lock=1, D valid constantly -> d_ready=0 until C accepts with lock=0; D is granted the cycle after.
REQ-035 C locks then idles 16 cycles -> FSM returns to ARB, lock_tmo=1 and stays 1; D is granted next.
REQ-036 rst asserted the cycle after a C read accept -> no c_rvalid; all outputs at reset values.
